booth_seq_mult: RTL



---
 rtl/booth_seq_mult_if.sv | 22 ++
 rtl/booth_seq_mult.sv | 132 +++++++++++++
 2 files changed

// File: rtl/booth_seq_mult_if.sv
// rtl/booth_seq_mult_if.sv - start/rdy handshake and operand/result bundle for booth_seq_mult
interface booth_seq_mult_if #(
  parameter int DP_WIDTH = 8
);
  logic                    start;
  logic                    signed_mode;
  logic [DP_WIDTH-1:0]     multiplicand;
  logic [DP_WIDTH-1:0]     multiplier;
  logic                    rdy;
  logic                    done;
  logic [2*DP_WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  rdy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output rdy, done, product
  );
endinterface

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - radix-2 Booth sequential multiplier, optional EARLY_TERM_EN shortcut
module booth_seq_mult #(
  parameter int DP_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_b,
  booth_seq_mult_if.slave bus
);
  // Operands carry one extra bit so unsigned values stay positive in the signed Booth datapath.
  localparam int N       = DP_WIDTH + 1;
  localparam int BC_SIZE = $clog2(DP_WIDTH + 2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [BC_SIZE-1:0] P_INIT = BC_SIZE'(N);
  localparam logic [BC_SIZE-1:0] P_ONE  = BC_SIZE'(1);

  logic [0:0]              r_state;
  logic [N-1:0]            r_a;
  logic [N-1:0]            r_q;
  logic [N-1:0]            r_m;
  logic                    r_q_m1;
  logic [BC_SIZE-1:0]      r_p;
  logic                    r_done;
  logic [2*DP_WIDTH-1:0]   r_product;

  logic [N-1:0]            w_m_ext;
  logic [N-1:0]            w_q_ext;
  logic [N-1:0]            w_a_add;
  logic signed [2*N:0]     w_step;
  logic [N-1:0]            w_a_nxt;
  logic [N-1:0]            w_q_nxt;
  logic                    w_q_m1_nxt;
  logic                    w_last;

  assign w_m_ext = {bus.signed_mode & bus.multiplicand[DP_WIDTH-1], bus.multiplicand};
  assign w_q_ext = {bus.signed_mode & bus.multiplier[DP_WIDTH-1], bus.multiplier};

  // Booth add/subtract selected by the current bit pair; the carry out is dropped.
  always_comb begin
    w_a_add = r_a;
    case ({r_q[0], r_q_m1})
      2'b01:   w_a_add = r_a + r_m;
      2'b10:   w_a_add = r_a - r_m;
      default: w_a_add = r_a;
    endcase
  end

  assign w_step = $signed({w_a_add, r_q, r_q_m1}) >>> 1;

`ifdef EARLY_TERM_EN
  logic [N-1:0]            w_mask;
  logic                    w_et;
  logic signed [2*N:0]     w_jump;

  // Mask of the P bits of Q that still have to be scanned.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (BC_SIZE'(i) < r_p);
    end
  end

  // When every unscanned bit equals Q_-1 the rest are pure shifts and can be done at once.
  assign w_et   = (((r_q ^ {N{r_q_m1}}) & w_mask) == '0);
  assign w_jump = $signed({r_a, r_q, r_q_m1}) >>> r_p;

  // Choose between a single Booth step and the collapsed shift-by-P.
  always_comb begin
    if (w_et) begin
      {w_a_nxt, w_q_nxt, w_q_m1_nxt} = w_jump;
      w_last = 1'b1;
    end else begin
      {w_a_nxt, w_q_nxt, w_q_m1_nxt} = w_step;
      w_last = (r_p == P_ONE);
    end
  end
`else
  // Plain one-step-per-cycle iteration.
  always_comb begin
    {w_a_nxt, w_q_nxt, w_q_m1_nxt} = w_step;
    w_last = (r_p == P_ONE);
  end
`endif

  // Control FSM and datapath registers; product only changes when an operation completes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q_m1    <= 1'b0;
      r_p       <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_a     <= '0;
            r_q     <= w_q_ext;
            r_m     <= w_m_ext;
            r_q_m1  <= 1'b0;
            r_p     <= P_INIT;
          end
        end
        S_RUN: begin
          r_a    <= w_a_nxt;
          r_q    <= w_q_nxt;
          r_q_m1 <= w_q_m1_nxt;
          if (w_last) begin
            r_p       <= '0;
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_product <= {w_a_nxt[DP_WIDTH-2:0], w_q_nxt};
          end else begin
            r_p <= r_p - P_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdy     = (r_state == S_IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule
